// File: rtl/mult_pkg.sv
// Shared types for the shift-and-add multiplier.
// Holds the FSM state encoding and the counter-width helper.
package mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } mult_state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/adder_n.sv
// N-bit ripple-carry adder.
// Carry threads bit by bit from c_in to c_out.
module adder_n #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);

  logic cy;

  always_comb begin
    sum = '0;
    cy  = c_in;
    for (int i = 0; i < N; i++) begin
      sum[i] = a[i] ^ b[i] ^ cy;
      cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    c_out = cy;
  end

endmodule

// File: rtl/mult_shift_add.sv
// Sequential unsigned multiplier, one multiplier bit per clock.
// Optional MULT_OVF_EN adds an ovf flag registered with product.
module mult_shift_add
  import mult_pkg::*;
#(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product
`ifdef MULT_OVF_EN
  ,
  output logic           ovf
`endif
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  mult_state_t    state;
  logic [N-1:0]   a_q;
  logic [2*N-1:0] p_q;
  logic [CW-1:0]  cnt;

  logic [N-1:0]   add_a;
  logic [N-1:0]   add_b;
  logic [N-1:0]   add_sum;
  logic           add_co;
  logic [2*N-1:0] p_nxt;

  assign add_a = p_q[2*N-1:N];
  assign add_b = p_q[0] ? a_q : '0;

  // carry-out lands in the top bit, so nothing is lost
  assign p_nxt = {add_co, add_sum, p_q[N-1:1]};

  adder_n #(
    .N(N)
  ) adder_partial (
    .a    (add_a),
    .b    (add_b),
    .c_in (1'b0),
    .sum  (add_sum),
    .c_out(add_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      product   <= '0;
      a_q       <= '0;
      p_q       <= '0;
      cnt       <= '0;
`ifdef MULT_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a;
            p_q      <= {{N{1'b0}}, b};
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          p_q <= p_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            product   <= p_nxt;
            out_valid <= 1'b1;
`ifdef MULT_OVF_EN
            ovf       <= |p_nxt[2*N-1:N];
`endif
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_shift_add.sv
// Bench for mult_shift_add: directed N=8 cases plus N=32 random traffic.
// Expected products come from plain integer multiplication.
module tb_mult_shift_add;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        iv8, ir8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        iv32, ir32, ov32, or32;
  logic [31:0] a32, b32;
  logic [63:0] p32;
`ifdef MULT_OVF_EN
  logic        ovf8, ovf32;
`endif

  mult_shift_add #(.N(8)) dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (iv8),
    .in_ready (ir8),
    .a        (a8),
    .b        (b8),
    .out_valid(ov8),
    .out_ready(or8),
    .product  (p8)
`ifdef MULT_OVF_EN
    ,
    .ovf      (ovf8)
`endif
  );

  mult_shift_add #(.N(32)) dut32 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (iv32),
    .in_ready (ir32),
    .a        (a32),
    .b        (b32),
    .out_valid(ov32),
    .out_ready(or32),
    .product  (p32)
`ifdef MULT_OVF_EN
    ,
    .ovf      (ovf32)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand pair on dut8 and wait for its product.
  task automatic run8(input string tag, input logic [7:0] x,
                      input logic [7:0] y, output logic [15:0] exp);
    int lat;
    int hi_rdy;
    exp = 16'(x) * 16'(y);
    chk({tag, "_rdy_before"}, 64'(ir8), 64'd1);
    iv8 = 1'b1;
    a8  = x;
    b8  = y;
    step();
    iv8 = 1'b0;
    a8  = 8'($urandom);
    b8  = 8'($urandom);
    lat = 0;
    hi_rdy = 0;
    while (!ov8 && lat < 40) begin
      if (ir8) hi_rdy++;
      step();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd8);
    chk({tag, "_rdy_busy"}, 64'(hi_rdy), 64'd0);
    chk({tag, "_product"}, 64'(p8), 64'(exp));
`ifdef MULT_OVF_EN
    chk({tag, "_ovf"}, 64'(ovf8), 64'(exp[15:8] != 8'd0));
`endif
  endtask

  task automatic handoff8(input string tag);
    or8 = 1'b1;
    step();
    chk({tag, "_valid_drop"}, 64'(ov8), 64'd0);
    chk({tag, "_rdy_back"}, 64'(ir8), 64'd1);
  endtask

  function automatic logic [31:0] pick();
    unique case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [63:0] sb[$];

  initial begin
    logic [15:0] e;
    logic [15:0] held;
    int got;
    rst_n = 1'b0;
    iv8 = 0; or8 = 0; a8 = 0; b8 = 0;
    iv32 = 0; or32 = 0; a32 = 0; b32 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();

    chk("rst_rdy8", 64'(ir8), 64'd1);
    chk("rst_valid8", 64'(ov8), 64'd0);
    chk("rst_prod8", 64'(p8), 64'd0);
    chk("rst_rdy32", 64'(ir32), 64'd1);
    chk("rst_valid32", 64'(ov32), 64'd0);
    chk("rst_prod32", p32, 64'd0);
`ifdef MULT_OVF_EN
    chk("rst_ovf8", 64'(ovf8), 64'd0);
`endif

    or8 = 1'b1;
    run8("m13x11", 8'd13, 8'd11, e);
    chk("m13x11_is143", 64'(e), 64'd143);
    handoff8("m13x11");
    run8("mffxff", 8'hFF, 8'hFF, e);
    handoff8("mffxff");
    run8("m15x17", 8'd15, 8'd17, e);
    handoff8("m15x17");
    run8("m0xaa", 8'd0, 8'hAA, e);
    handoff8("m0xaa");
    run8("maax0", 8'hAA, 8'd0, e);
    handoff8("maax0");

    // backpressure: result must hold while the sink stalls
    or8 = 1'b0;
    run8("bp", 8'd200, 8'd100, held);
    for (int i = 0; i < 5; i++) begin
      iv8 = 1'b1;
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      step();
      chk("bp_valid_hold", 64'(ov8), 64'd1);
      chk("bp_prod_hold", 64'(p8), 64'(held));
      chk("bp_rdy_low", 64'(ir8), 64'd0);
    end
    iv8 = 1'b0;
    handoff8("bp");
    step();
    chk("bp_no_stray_accept", 64'(ir8), 64'd1);

    // asynchronous reset three cycles into a run
    iv8 = 1'b1;
    a8  = 8'd99;
    b8  = 8'd3;
    step();
    iv8 = 1'b0;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(ov8), 64'd0);
    chk("mid_rst_prod", 64'(p8), 64'd0);
    chk("mid_rst_rdy", 64'(ir8), 64'd1);
    @(negedge clk) rst_n = 1'b1;
    step();
    run8("m7x6", 8'd7, 8'd6, e);
    handoff8("m7x6");

    got = 0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          int w;
          repeat ($urandom_range(0, 3)) step();
          a32  = pick();
          b32  = pick();
          iv32 = 1'b1;
          w = 0;
          while (!ir32 && w < 300) begin
            step();
            w++;
          end
          chk("rnd_accept_wait", 64'(ir32), 64'd1);
          sb.push_back(64'(a32) * 64'(b32));
          step();
          iv32 = 1'b0;
          a32  = $urandom;
          b32  = $urandom;
        end
      end
      begin
        int cyc;
        logic [63:0] x;
        cyc = 0;
        while (got < 200 && cyc < 20000) begin
          or32 = ($urandom_range(0, 3) != 0);
          if (ov32 && or32) begin
            if (sb.size() == 0) begin
              chk("rnd_spurious", 64'd0, 64'd1);
            end else begin
              x = sb.pop_front();
              chk("rnd_product", p32, x);
`ifdef MULT_OVF_EN
              chk("rnd_ovf", 64'(ovf32), 64'(x[63:32] != 32'd0));
`endif
            end
            got++;
          end
          step();
          cyc++;
        end
        or32 = 1'b0;
      end
    join

    repeat (40) step();
    chk("rnd_count", 64'(got), 64'd200);
    chk("rnd_sb_empty", 64'(sb.size()), 64'd0);
    chk("rnd_no_extra", 64'(ov32), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
